// File: rtl/score_counter.sv
// BCD game score counter: run/over FSM, prescaled tick points, bonus add, wrap or saturate.
// Optional high-score tracking is built only when SCORE_COUNTER_HISCORE_EN is defined.
module score_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned WRAP     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_start,
  input  logic                game_over,
  input  logic                game_tick,
  input  logic                bonus_valid,
  input  logic [3:0]          bonus_val,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] hi_score,
  output logic                active,
  output logic                rollover,
  output logic                new_hi
);

  localparam int unsigned       W        = 4 * DIGITS;
  localparam logic [W-1:0]      MAX_BCD  = {DIGITS{4'h9}};
  localparam logic [7:0]        DIV_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } state_e;

  state_e       state_q, state_d;
  logic         active_q, active_d;
  logic [7:0]   presc_q, presc_d;
  logic [W-1:0] score_q, score_d;
  logic         roll_q, roll_d;

  logic         tick_pt;
  logic [3:0]   bonus_c;
  logic [3:0]   inc;
  logic [W-1:0] sum_bcd;
  logic         carry_out;
  logic [4:0]   dsum;
  logic         cy;
  logic [W-1:0] score_inc;
  logic         roll_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  // Next-state logic: start wins over over, and is honoured from any state
  always_comb begin
    state_d = state_q;
    if (game_start) begin
      state_d = RUN;
    end else if ((state_q == RUN) && game_over) begin
      state_d = OVER;
    end
  end

  // Output logic
  always_comb begin
    active_d = (state_d == RUN);
  end

  always_comb begin
    tick_pt = (state_q == RUN) && game_tick && (presc_q == DIV_LAST);
    bonus_c = (bonus_val > 4'd9) ? 4'd9 : bonus_val;
    inc     = (tick_pt ? 4'd1 : 4'd0) + (bonus_valid ? bonus_c : 4'd0);
  end

  // Increment enters digit 0; later digits only ever see a carry of one
  always_comb begin
    sum_bcd = '0;
    cy      = 1'b0;
    dsum    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, score_q[4*i +: 4]} + ((i == 0) ? {1'b0, inc} : {4'b0000, cy});
      if (dsum >= 5'd10) begin
        sum_bcd[4*i +: 4] = 4'(dsum - 5'd10);
        cy                = 1'b1;
      end else begin
        sum_bcd[4*i +: 4] = dsum[3:0];
        cy                = 1'b0;
      end
    end
    carry_out = cy;
  end

  always_comb begin
    score_inc = sum_bcd;
    roll_inc  = carry_out;
    if (WRAP == 0) begin
      if (score_q == MAX_BCD) begin
        score_inc = score_q;
        roll_inc  = 1'b0;
      end else if (carry_out || (sum_bcd == MAX_BCD)) begin
        score_inc = MAX_BCD;
        roll_inc  = 1'b1;
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    score_d = score_q;
    roll_d  = 1'b0;
    if (game_start) begin
      presc_d = '0;
      score_d = '0;
    end else if (state_q == RUN) begin
      if (game_tick) begin
        presc_d = (presc_q == DIV_LAST) ? '0 : presc_q + 8'd1;
      end
      score_d = score_inc;
      roll_d  = roll_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      score_q <= '0;
      roll_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      score_q <= score_d;
      roll_q  <= roll_d;
    end
  end

`ifdef SCORE_COUNTER_HISCORE_EN
  logic [W-1:0] hi_q, hi_d;
  logic         new_hi_q, new_hi_d;

  // Packed BCD orders the same as its binary reading, so a plain compare suffices
  always_comb begin
    hi_d     = hi_q;
    new_hi_d = 1'b0;
    if (!game_start && (state_q == RUN) && game_over && (score_d > hi_q)) begin
      hi_d     = score_d;
      new_hi_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      new_hi_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      new_hi_q <= new_hi_d;
    end
  end

  assign hi_score = hi_q;
  assign new_hi   = new_hi_q;
`else
  assign hi_score = '0;
  assign new_hi   = 1'b0;
`endif

  assign score    = score_q;
  assign active   = active_q;
  assign rollover = roll_q;

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: three parameterisations driven in parallel,
// compared every cycle against an integer-arithmetic reference model.
module tb_score_counter;

  localparam int unsigned MAXV = 9999;
`ifdef SCORE_COUNTER_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        gs = 1'b0, go = 1'b0, gt = 1'b0, bv = 1'b0;
  logic [3:0]  bval = 4'd0;

  logic [15:0] sc [3];
  logic [15:0] hi [3];
  logic        act [3];
  logic        rol [3];
  logic        nh  [3];

  always #5 clk = ~clk;

  score_counter #(.DIGITS(4), .TICK_DIV(1), .WRAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .game_start(gs), .game_over(go), .game_tick(gt),
    .bonus_valid(bv), .bonus_val(bval), .score(sc[0]), .hi_score(hi[0]),
    .active(act[0]), .rollover(rol[0]), .new_hi(nh[0]));

  score_counter #(.DIGITS(4), .TICK_DIV(3), .WRAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .game_start(gs), .game_over(go), .game_tick(gt),
    .bonus_valid(bv), .bonus_val(bval), .score(sc[1]), .hi_score(hi[1]),
    .active(act[1]), .rollover(rol[1]), .new_hi(nh[1]));

  score_counter #(.DIGITS(4), .TICK_DIV(1), .WRAP(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .game_start(gs), .game_over(go), .game_tick(gt),
    .bonus_valid(bv), .bonus_val(bval), .score(sc[2]), .hi_score(hi[2]),
    .active(act[2]), .rollover(rol[2]), .new_hi(nh[2]));

  typedef enum int {M_IDLE, M_RUN, M_OVER} mst_t;
  typedef struct {
    mst_t        st;
    int unsigned presc;
    int unsigned score;
    int unsigned hi;
    bit          act;
    bit          roll;
    bit          nh;
  } mdl_t;

  typedef struct {
    bit          s, o, t, b;
    logic [3:0]  v;
    logic [15:0] esc;
    bit          eact;
    bit          erol;
  } vec_t;

  mdl_t        m [3];
  int unsigned tdiv [3] = '{1, 3, 1};
  bit          wrp  [3] = '{1'b1, 1'b1, 1'b0};
  int          checks = 0;
  int          failures = 0;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = M_IDLE; r.presc = 0; r.score = 0; r.hi = 0;
    r.act = 1'b0; r.roll = 1'b0; r.nh = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t c, int unsigned div, bit wrap,
                                 bit s, bit o, bit t, bit b, logic [3:0] v);
    mdl_t        n = c;
    int unsigned add, sum, bonus;
    n.roll = 1'b0;
    n.nh   = 1'b0;
    if (s) begin
      n.st = M_RUN; n.score = 0; n.presc = 0;
    end else if (c.st == M_RUN) begin
      add = 0;
      if (t) begin
        if (c.presc == div - 1) begin n.presc = 0; add = 1; end
        else n.presc = c.presc + 1;
      end
      bonus = (int'(v) > 9) ? 9 : int'(v);
      if (b) add += bonus;
      sum = c.score + add;
      if (wrap) begin
        if (sum > MAXV) begin n.score = sum - (MAXV + 1); n.roll = 1'b1; end
        else n.score = sum;
      end else if (c.score != MAXV) begin
        if (sum >= MAXV) begin n.score = MAXV; n.roll = 1'b1; end
        else n.score = sum;
      end
      if (o) begin
        n.st = M_OVER;
        if (HI_EN && (n.score > c.hi)) begin n.hi = n.score; n.nh = 1'b1; end
      end
    end
    n.act = (n.st == M_RUN);
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(int unsigned v);
    logic [15:0] r;
    int unsigned x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("score[%0d]", i),  sc[i],        to_bcd(m[i].score));
      chk($sformatf("hi[%0d]", i),     hi[i],        to_bcd(m[i].hi));
      chk($sformatf("active[%0d]", i), 16'(act[i]),  16'(m[i].act));
      chk($sformatf("roll[%0d]", i),   16'(rol[i]),  16'(m[i].roll));
      chk($sformatf("new_hi[%0d]", i), 16'(nh[i]),   16'(m[i].nh));
    end
  endtask

  task automatic cyc(bit s, bit o, bit t, bit b, logic [3:0] v);
    gs = s; go = o; gt = t; bv = b; bval = v;
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], tdiv[i], wrp[i], s, o, t, b, v);
    #1;
    check_all();
  endtask

  // Reset asserted and released between clock edges
  task automatic hard_reset();
    gs = 1'b0; go = 1'b0; gt = 1'b0; bv = 1'b0; bval = 4'd0;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = mreset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_score[%0d]", i), sc[i], 16'h0000);
      chk($sformatf("rst_act[%0d]", i), 16'(act[i]), 16'h0000);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{s:1, o:0, t:0, b:0, v:4'd0,  esc:16'h0000, eact:1, erol:0};
    tbl[1] = '{s:0, o:0, t:1, b:0, v:4'd0,  esc:16'h0001, eact:1, erol:0};
    tbl[2] = '{s:0, o:0, t:1, b:1, v:4'd5,  esc:16'h0007, eact:1, erol:0};
    tbl[3] = '{s:0, o:0, t:0, b:1, v:4'd12, esc:16'h0016, eact:1, erol:0};
    tbl[4] = '{s:0, o:0, t:1, b:0, v:4'd9,  esc:16'h0017, eact:1, erol:0};
    tbl[5] = '{s:0, o:1, t:1, b:0, v:4'd0,  esc:16'h0018, eact:0, erol:0};
    tbl[6] = '{s:0, o:0, t:1, b:1, v:4'd3,  esc:16'h0018, eact:0, erol:0};
    tbl[7] = '{s:1, o:1, t:0, b:0, v:4'd0,  esc:16'h0000, eact:1, erol:0};
    tbl[8] = '{s:0, o:0, t:1, b:0, v:4'd0,  esc:16'h0001, eact:1, erol:0};

    for (int i = 0; i < 3; i++) m[i] = mreset();
    hard_reset();

    // Ticks before any start are ignored
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 4'd4);
    chk("idle_hold", sc[0], 16'h0000);

    for (int k = 0; k < 9; k++) begin
      cyc(tbl[k].s, tbl[k].o, tbl[k].t, tbl[k].b, tbl[k].v);
      chk($sformatf("tbl%0d_score", k), sc[0], tbl[k].esc);
      chk($sformatf("tbl%0d_act", k), 16'(act[0]), 16'(tbl[k].eact));
      chk($sformatf("tbl%0d_roll", k), 16'(rol[0]), 16'(tbl[k].erol));
    end

    // Basic count
    hard_reset();
    cyc(1, 0, 0, 0, 4'd0);
    for (int k = 0; k < 1234; k++) cyc(0, 0, 1, 0, 4'd0);
    chk("count_a", sc[0], 16'h1234);
    chk("count_b", sc[1], 16'h0411);
    chk("count_act", 16'(act[0]), 16'h0001);

    // Prescale and bonus
    hard_reset();
    cyc(1, 0, 0, 0, 4'd0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, 4'd0);
    chk("presc6_b", sc[1], 16'h0002);
    cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 0, 1, 1, 4'd9);
    chk("presc9_b", sc[1], 16'h0012);

    // Wrap vs saturate at 9998 + 5
    hard_reset();
    cyc(1, 0, 0, 0, 4'd0);
    for (int k = 0; k < 999; k++) cyc(0, 0, 1, 1, 4'd9);
    cyc(0, 0, 1, 1, 4'd7);
    chk("pre_wrap_a", sc[0], 16'h9998);
    chk("pre_sat_c", sc[2], 16'h9998);
    cyc(0, 0, 0, 1, 4'd5);
    chk("wrap_a", sc[0], 16'h0003);
    chk("wrap_roll_a", 16'(rol[0]), 16'h0001);
    chk("sat_c", sc[2], 16'h9999);
    chk("sat_roll_c", 16'(rol[2]), 16'h0001);
    cyc(0, 0, 1, 0, 4'd0);
    chk("post_wrap_a", sc[0], 16'h0004);
    chk("post_wrap_roll_a", 16'(rol[0]), 16'h0000);
    chk("post_sat_c", sc[2], 16'h9999);
    chk("post_sat_roll_c", 16'(rol[2]), 16'h0000);

    // High score across two runs
    hard_reset();
    cyc(1, 0, 0, 0, 4'd0);
    for (int k = 0; k < 42; k++) cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    chk("hi_run1", hi[0], HI_EN ? 16'h0042 : 16'h0000);
    chk("new_hi_run1", 16'(nh[0]), HI_EN ? 16'h0001 : 16'h0000);
    cyc(0, 0, 0, 0, 4'd0);
    chk("new_hi_pulse_end", 16'(nh[0]), 16'h0000);
    cyc(1, 0, 0, 0, 4'd0);
    for (int k = 0; k < 17; k++) cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    chk("hi_run2", hi[0], HI_EN ? 16'h0042 : 16'h0000);
    chk("new_hi_run2", 16'(nh[0]), 16'h0000);

    // Simultaneous start/over, then ticks in OVER
    cyc(1, 0, 0, 0, 4'd0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 4'd0);
    cyc(1, 1, 1, 0, 4'd0);
    chk("simul_score", sc[0], 16'h0000);
    chk("simul_act", 16'(act[0]), 16'h0001);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 1, 0, 0, 4'd0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 4'd6);
    chk("over_hold", sc[0], 16'h0003);
    chk("over_act", 16'(act[0]), 16'h0000);

    // Reset mid-run
    hard_reset();
    cyc(1, 0, 0, 0, 4'd0);
    for (int k = 0; k < 250; k++) cyc(0, 0, 1, 0, 4'd0);
    chk("pre_rst", sc[0], 16'h0250);
    hard_reset();
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 4'd3);
    chk("post_rst_hold", sc[0], 16'h0000);
    cyc(1, 0, 0, 0, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 0, 1, 0, 4'd0);
    chk("post_rst_run", sc[0], 16'h0002);

    // Randomised traffic against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(799) == 0) begin
        hard_reset();
      end else begin
        cyc(($urandom_range(299) == 0), ($urandom_range(199) == 0),
            ($urandom_range(1) == 1), ($urandom_range(1) == 1),
            4'($urandom_range(15)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
